// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multi-cycle multiply/divide unit:
//   op codes, FSM state encoding, default parameter values and small
//   op-classification helpers used by both the top level and the core.
package muldiv_pkg;

  // Op codes presented on i_op together with i_start.
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  // FSM states. IDLE: no operation in flight. RUN: latency counter active.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default parameter values.
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;
  localparam int DEF_CNT_W   = 4;

  // True for ops that occupy the unit for MUL_LAT cycles.
  function automatic logic is_mul_op(logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // True for ops that occupy the unit for DIV_LAT cycles.
  function automatic logic is_div_op(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core
//   Purely combinational arithmetic for the multiply/divide unit. Produces
//   the {HI, LO} pair for MULT/MULTU/DIV/DIVU from the latched op and
//   operands. The top level holds the operands stable for the whole
//   latency window and only samples the result on the completion edge.
//
// Ports:
//   i_op   op code (muldiv_pkg)
//   i_a    operand rs (dividend / multiplicand)
//   i_b    operand rt (divisor / multiplier)
//   o_hi   HI result: product upper half, or remainder
//   o_lo   LO result: product lower half, or quotient
//   Non-arithmetic op codes give an all-zero result.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int               W2       = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_sgn;
  logic [W2-1:0]    w_a_ext;
  logic [W2-1:0]    w_b_ext;
  logic [W2-1:0]    w_prod;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_divisor;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_sgn = is_signed_op(i_op);

  // Multiply: extend both operands to 2*WIDTH (sign or zero) and keep the
  // low 2*WIDTH bits of the product. Modulo 2^(2*WIDTH) this equals the
  // exact signed product, so one unsigned multiplier serves both ops.
  assign w_a_ext = {{WIDTH{w_sgn & i_a[WIDTH-1]}}, i_a};
  assign w_b_ext = {{WIDTH{w_sgn & i_b[WIDTH-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide: sign-magnitude approach. Divide magnitudes unsigned, then
  // negate the quotient when operand signs differ and the remainder when
  // the dividend is negative (truncation toward zero).
  assign w_a_neg = w_sgn & i_a[WIDTH-1];
  assign w_b_neg = w_sgn & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (ZERO - i_a) : i_a;
  assign w_b_mag = w_b_neg ? (ZERO - i_b) : i_b;

  assign w_div_zero = (i_b == ZERO);
  // MOST_NEG / -1 does not fit in WIDTH bits; result is pinned explicitly.
  assign w_div_ovf  = (i_op == OP_DIV) && (i_a == MOST_NEG) && (i_b == ALL_ONES);

  // Substitute a harmless divisor on divide-by-zero so the divider never
  // sees zero; its output is overridden below anyway.
  assign w_divisor = w_div_zero ? ONE : w_b_mag;
  assign w_uq      = w_a_mag / w_divisor;
  assign w_ur      = w_a_mag % w_divisor;
  assign w_q       = (w_a_neg ^ w_b_neg) ? (ZERO - w_uq) : w_uq;
  assign w_r       = w_a_neg ? (ZERO - w_ur) : w_ur;

  always_comb begin
    o_hi = ZERO;
    o_lo = ZERO;
    case (i_op)
      OP_MULT, OP_MULTU: begin
        o_hi = w_prod[W2-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
      end
      OP_DIV, OP_DIVU: begin
        if (w_div_zero) begin
          o_hi = i_a;
          o_lo = ALL_ONES;
        end else if (w_div_ovf) begin
          o_hi = ZERO;
          o_lo = i_a;
        end else begin
          o_hi = w_r;
          o_lo = w_q;
        end
      end
      default: begin
        o_hi = ZERO;
        o_lo = ZERO;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   MULT/MULTU hold the unit busy for MUL_LAT cycles, DIV/DIVU for DIV_LAT
//   cycles; MTHI/MTLO write HI/LO directly on the accepting edge. Busy lets
//   hazard logic stall MFHI/MFLO and further mul/div ops. A flush cancels
//   the in-flight operation without touching HI/LO.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   i_start      operation request, sampled every cycle
//   i_op         op code (muldiv_pkg)
//   i_a          operand rs
//   i_b          operand rt
//   i_flush      cancel in-flight operation
//   o_busy       operation in progress
//   o_done       one-cycle pulse when HI/LO take a mul/div result
//   o_hi         HI register
//   o_lo         LO register
//   o_dbg_state  current FSM state (state_t encoding)
//
// Handshake: i_start acts as 'valid' and ~o_busy as 'ready'. A request is
// taken on a rising edge where i_start=1, o_busy=0 and i_flush=0. There is
// no queue: a request made while busy (or together with flush) is dropped
// and the requester must stall and retry. o_busy is low in the o_done
// cycle, so a new request there is accepted with no idle gap.
//
// CNT_W must satisfy 2**CNT_W > max(MUL_LAT, DIV_LAT); both latencies >= 1.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [0:0]       o_dbg_state
);

  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  // Result is a combinational function of the latched operands; it is
  // only sampled into HI/LO on the completion edge.
  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_hi (w_hi_res),
    .o_lo (w_lo_res)
  );

  assign w_accept = i_start & (r_state == ST_IDLE) & ~i_flush;
  assign w_last   = (r_cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_op    <= OP_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (i_op)
              OP_MULT, OP_MULTU: begin
                r_op    <= i_op;
                r_a     <= i_a;
                r_b     <= i_b;
                r_cnt   <= MUL_CNT;
                r_state <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_op    <= i_op;
                r_a     <= i_a;
                r_b     <= i_b;
                r_cnt   <= DIV_CNT;
                r_state <= ST_RUN;
              end
              OP_MTHI: r_hi <= i_a;
              OP_MTLO: r_lo <= i_a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Flush has priority even on the completion edge: no write.
          if (i_flush) begin
            r_cnt   <= CNT_ZERO;
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_hi    <= w_hi_res;
            r_lo    <= w_lo_res;
            r_done  <= 1'b1;
            r_cnt   <= CNT_ZERO;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = r_done;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [0:0]    dbg_state;

  int            n_vec = 0;
  int            n_err = 0;
  logic [W-1:0]  m_hi;
  logic [W-1:0]  m_lo;

  muldiv_unit #(
    .WIDTH   (W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_done      (done),
    .o_hi        (hi),
    .o_lo        (lo),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural HI/LO effect of one accepted op,
  // computed with native 64-bit arithmetic.
  function automatic void ref_model(input logic [2:0] mop, input logic [W-1:0] ma,
                                    input logic [W-1:0] mb,
                                    inout logic [W-1:0] rhi, inout logic [W-1:0] rlo);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    case (mop)
      OP_MULT: begin
        sp  = sa * sb;
        rhi = sp[63:32];
        rlo = sp[31:0];
      end
      OP_MULTU: begin
        up  = ua * ub;
        rhi = up[63:32];
        rlo = up[31:0];
      end
      OP_DIV: begin
        if (mb == 0) begin
          rhi = ma;
          rlo = '1;
        end else begin
          sp  = sa / sb;
          rlo = sp[31:0];
          sp  = sa % sb;
          rhi = sp[31:0];
        end
      end
      OP_DIVU: begin
        if (mb == 0) begin
          rhi = ma;
          rlo = '1;
        end else begin
          up  = ua / ub;
          rlo = up[31:0];
          up  = ua % ub;
          rhi = up[31:0];
        end
      end
      OP_MTHI: rhi = ma;
      OP_MTLO: rlo = ma;
      default: ;
    endcase
  endfunction

  // Driver: issue one op from an idle/done cycle, follow it through its
  // latency and return in the cycle after completion (the done cycle for
  // mul/div), so a following call starts back-to-back.
  task automatic do_op(input logic [2:0] dop, input logic [W-1:0] da,
                       input logic [W-1:0] db, input string tag);
    int lat;
    lat = (dop == OP_MULT || dop == OP_MULTU) ? MUL_LAT :
          (dop == OP_DIV  || dop == OP_DIVU)  ? DIV_LAT : 0;
    ref_model(dop, da, db, m_hi, m_lo);
    start = 1'b1;
    op    = dop;
    a     = da;
    b     = db;
    step();
    start = 1'b0;
    if (lat == 0) begin
      chk($sformatf("%s.busy", tag), W'(busy), W'(0));
      chk($sformatf("%s.done", tag), W'(done), W'(0));
    end else begin
      for (int k = 0; k < lat; k++) begin
        if (k == 0) chk($sformatf("%s.state", tag), W'(dbg_state), W'(ST_RUN));
        chk($sformatf("%s.busy[%0d]", tag, k), W'(busy), W'(1));
        chk($sformatf("%s.done[%0d]", tag, k), W'(done), W'(0));
        step();
      end
      chk($sformatf("%s.busy_end", tag), W'(busy), W'(0));
      chk($sformatf("%s.done_end", tag), W'(done), W'(1));
    end
    chk($sformatf("%s.hi", tag), hi, m_hi);
    chk($sformatf("%s.lo", tag), lo, m_lo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = OP_NONE;
    a     = '0;
    b     = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy",  W'(busy), W'(0));
    chk("rst.done",  W'(done), W'(0));
    chk("rst.hi",    hi, 32'h0);
    chk("rst.lo",    lo, 32'h0);
    chk("rst.state", W'(dbg_state), W'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // MULT / MULTU of -2 and 3.
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult");
    chk("mult.hi_k", hi, 32'hFFFF_FFFF);
    chk("mult.lo_k", lo, 32'hFFFF_FFFA);
    step();
    chk("mult.done_once", W'(done), W'(0));
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    chk("multu.hi_k", hi, 32'h0000_0002);
    chk("multu.lo_k", lo, 32'hFFFF_FFFA);
    step();

    // Divides, issued back-to-back from each done cycle.
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div.lo_k", lo, 32'hFFFF_FFFD);
    chk("div.hi_k", hi, 32'hFFFF_FFFF);
    do_op(OP_DIVU, 32'd7, 32'd0, "divu0");
    chk("divu0.lo_k", lo, 32'hFFFF_FFFF);
    chk("divu0.hi_k", hi, 32'h0000_0007);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    chk("divovf.lo_k", lo, 32'h8000_0000);
    chk("divovf.hi_k", hi, 32'h0000_0000);
    step();

    // Direct writes and no-op codes.
    do_op(OP_MTHI, 32'h1234_5678, 32'd0, "mthi");
    chk("mthi.hi_k", hi, 32'h1234_5678);
    do_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, "mtlo");
    do_op(OP_NONE, 32'hDEAD_BEEF, 32'd1, "opnone");
    do_op(3'b111,  32'hDEAD_BEEF, 32'd1, "opundef");

    // Start while busy: dropped, original result lands on time.
    ref_model(OP_MULT, 32'd6, 32'd7, m_hi, m_lo);
    start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
    step();
    for (int k = 0; k < MUL_LAT; k++) begin
      if (k == 2) begin
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd5;
      end else begin
        start = 1'b0;
      end
      chk("ign.busy", W'(busy), W'(1));
      step();
    end
    start = 1'b0;
    chk("ign.done", W'(done), W'(1));
    chk("ign.hi", hi, 32'd0);
    chk("ign.lo", lo, 32'd42);
    step();
    chk("ign.noqueue", W'(busy), W'(0));

    // Flush on the completion cycle: no write, no done.
    start = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd3;
    step();
    start = 1'b0;
    for (int k = 0; k < DIV_LAT; k++) begin
      if (k == DIV_LAT - 1) flush = 1'b1;
      chk("flush.busy", W'(busy), W'(1));
      step();
    end
    flush = 1'b0;
    chk("flush.busy_end", W'(busy), W'(0));
    chk("flush.done_end", W'(done), W'(0));
    chk("flush.hi", hi, m_hi);
    chk("flush.lo", lo, m_lo);
    step();
    chk("flush.done_late", W'(done), W'(0));

    // Flush together with start while idle: request dropped.
    flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'h5555_AAAA;
    step();
    flush = 1'b0; start = 1'b0;
    chk("flstart.busy", W'(busy), W'(0));
    chk("flstart.hi", hi, m_hi);

    // Mid-run flush.
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    step();
    start = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("midflush.busy", W'(busy), W'(0));
    chk("midflush.lo", lo, m_lo);

    // Back-to-back: second op issued in the done cycle of the first.
    do_op(OP_MULT, 32'd5, 32'd9, "b2b_a");
    do_op(OP_MULTU, 32'h8000_0001, 32'hFFFF_FFFF, "b2b_b");
    step();

    // Asynchronous reset mid-run.
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", W'(busy), W'(0));
    chk("arst.hi",   hi, 32'h0);
    chk("arst.lo",   lo, 32'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DIV_LAT + 2; k++) begin
      step();
      chk("arst.nodone", W'(done), W'(0));
    end

    // Randomised ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(rop, ra, rb, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers; the sequential companion to the single-cycle integer ALU in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes and holds results in HI/LO.
- Raises busy for a fixed, parameter-set latency so hazard logic can stall MFHI/MFLO and new mul/div ops.
- Supports flush for exception cancellation.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MUL_LAT, 5: busy cycles for MULT/MULTU (>=1).
- DIV_LAT, 10: busy cycles for DIV/DIVU (>=1).
- CNT_W, 4: latency counter width; must satisfy 2**CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request, sampled every cycle.
- op  in  3  op code (muldiv_pkg).
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- flush  in  1  cancel in-flight operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO take a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async on rst_n low): busy=0, done=0, hi=0, lo=0, counter=0, state IDLE, latched operands and result cleared. Release is synchronous to clk.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter active.
- Accept: start=1, busy=0, flush=0, op valid.
  - MULT/MULTU/DIV/DIVU: latch op/a/b, load counter with MUL_LAT or DIV_LAT, go to RUN.
  - MTHI: hi<=a on that edge, stay IDLE, done stays 0.
  - MTLO: lo<=a on that edge, stay IDLE, done stays 0.
  - OP_NONE or undefined codes: no effect.
- Ignored requests: start while busy=1 is ignored, with no queueing. Stalling the requester is upstream's job.
- Timing: if accepted at edge E0, busy=1 for exactly LAT cycles after E0. At edge E0+LAT, hi/lo are written, busy falls and done=1 for one cycle. An MFHI read in that cycle sees the new value.
- Back-to-back: start in the done cycle is accepted, so there is no idle gap.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH→2·WIDTH; hi=upper, lo=lower.
  - MULTU: same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divide corner cases:
  - b=0: lo = all ones, hi = a. Full DIV_LAT still elapses.
  - Signed overflow (a=most negative, b=-1): lo=a, hi=0.
- Result timing: the result may be computed at acceptance and held, or iteratively. Either way, only the latency behaviour is visible.
- Flush:
  - flush=1 in RUN: next edge returns to IDLE, busy=0, hi/lo unchanged, done=0.
  - flush with start in the same cycle: start is ignored.
  - flush on the completion edge (counter==1): flush wins and no write occurs.
- rst_n mid-operation: immediate return to reset values; the in-flight result is discarded.

Decomposition:
- muldiv_pkg holds:
  - op codes: OP_NONE=3'b000, OP_MULT=001, OP_MULTU=010, OP_DIV=011, OP_DIVU=100, OP_MTHI=101, OP_MTLO=110.
  - state encoding.
  - default latencies.
- Sub-module muldiv_core: combinational/iterative arithmetic, producing {hi_res, lo_res} from op/a/b. It includes the div-by-zero and overflow rules.
- Top level owns the FSM, counter, flush, and HI/LO registers.

Test Plan:
- Reset: rst_n low mid-RUN → busy=0, hi=0, lo=0 immediately (asynchronous); no done after release.
- MULT with a=32'hFFFF_FFFE (-2), b=3 → busy high 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done pulses once. MULTU with the same operands → hi=2, lo=32'hFFFF_FFFA.
- DIV with a=-7, b=2 → after 10 cycles lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU a=7, b=0 → lo=32'hFFFF_FFFF, hi=7.
- DIV with a=32'h8000_0000, b=32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
- MTHI a=32'h1234_5678 while idle → hi updates next edge, busy stays 0. Start MULT while busy → ignored, original result lands unchanged.
- DIV started, flush asserted on cycle 10 (counter==1) → busy drops, hi/lo keep prior values, done=0. Start in the done cycle of a normal MULT → accepted with no gap.
